// File: rtl/tinyodin_pkg.sv
// Shared types for the tinyODIN spike event scheduler: FSM state encoding,
// sweep phase encoding and a saturating increment used by the optional counter.
package tinyodin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_INTEG = 3'd3,
    ST_FIRE  = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_t;

  // Phase A drives the read/integrate strobe, phase B the write-back strobe.
  localparam logic PHASE_A = 1'b0;
  localparam logic PHASE_B = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/neuron_sweep_counter.sv
// Neuron index counter with a two-phase toggle; shared by the integrate and
// fire sweeps. The index holds at the terminal value instead of wrapping.
module neuron_sweep_counter
  import tinyodin_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  input  logic [M-1:0] max_idx,
  output logic [M-1:0] idx,
  output logic         phase,
  output logic         last
);

  logic [M-1:0] idx_r;
  logic         phase_r;

  // Index/phase register: A->B on every advance, then step the index unless at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= {M{1'b0}};
      phase_r <= PHASE_A;
    end else if (clear) begin
      idx_r   <= {M{1'b0}};
      phase_r <= PHASE_A;
    end else if (advance) begin
      if (phase_r == PHASE_A) begin
        phase_r <= PHASE_B;
      end else begin
        phase_r <= PHASE_A;
        if (idx_r != max_idx) begin
          idx_r <= idx_r + {{(M-1){1'b0}}, 1'b1};
        end else begin
          idx_r <= idx_r;
        end
      end
    end else begin
      idx_r   <= idx_r;
      phase_r <= phase_r;
    end
  end

  assign idx   = idx_r;
  assign phase = phase_r;
  assign last  = (phase_r == PHASE_B) && (idx_r == max_idx);

endmodule

// File: rtl/spike_event_scheduler.sv
// Per-tick spike event scheduler: pops presynaptic events, sweeps neurons to
// integrate each one, then runs a fire/refractory sweep. Optional macro
// SPIKE_SCHED_PERF_EN adds evt_count_o (FIFO pops in the last tick).
module spike_event_scheduler
  import tinyodin_pkg::*;
#(
  parameter int N          = 256,
  parameter int M          = 8,
  parameter int INPUT_RESO = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start_i,
  input  logic [M-1:0] max_neuron_i,
  input  logic         spikecore_done_i,
  input  logic         FIFO_empty_i,
  input  logic [M-1:0] FIFO_r_data_i,
  output logic         FIFO_r_en_o,
  output logic [M-1:0] count_o,
  output logic [M-1:0] neuron_idx_o,
  output logic         neuron_event_o,
  output logic         neuron_write_o,
  output logic         neuron_tref_o,
  output logic         busy_o,
  output logic         tick_done_o
`ifdef SPIKE_SCHED_PERF_EN
  ,
  output logic [15:0]  evt_count_o
`endif
);

  if (N != (1 << M)) begin : g_bad_width
    $error("spike_event_scheduler: N must equal 2**M");
  end
  if (INPUT_RESO < 1) begin : g_bad_reso
    $error("spike_event_scheduler: INPUT_RESO must be positive");
  end

  sched_state_t state_r, state_next;
  logic [M-1:0] max_r;
  logic [M-1:0] count_r;
  logic         sweep_clear;
  logic         sweep_advance;
  logic         sweep_last;
  logic         sweep_phase;
  logic [M-1:0] sweep_idx;
  logic         sweeping;

  neuron_sweep_counter #(.M(M)) u_sweep (
    .clk     (CLK),
    .rst     (RST),
    .clear   (sweep_clear),
    .advance (sweep_advance),
    .max_idx (max_r),
    .idx     (sweep_idx),
    .phase   (sweep_phase),
    .last    (sweep_last)
  );

  // Next-state logic; the sweep counter is zeroed on entry to either sweep.
  always_comb begin
    state_next  = state_r;
    sweep_clear = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!FIFO_empty_i) begin
          state_next = ST_LATCH;
        end else if (spikecore_done_i) begin
          state_next  = ST_FIRE;
          sweep_clear = 1'b1;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_LATCH: begin
        state_next  = ST_INTEG;
        sweep_clear = 1'b1;
      end
      ST_INTEG: begin
        if (sweep_last) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_INTEG;
        end
      end
      ST_FIRE: begin
        if (sweep_last) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_FIRE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, sampled sweep limit and latched presynaptic address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      max_r   <= {M{1'b0}};
      count_r <= {M{1'b0}};
    end else begin
      state_r <= state_next;
      if ((state_r == ST_IDLE) && start_i) begin
        max_r <= max_neuron_i;
      end else begin
        max_r <= max_r;
      end
      if (state_r == ST_LATCH) begin
        count_r <= FIFO_r_data_i;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign sweeping      = (state_r == ST_INTEG) || (state_r == ST_FIRE);
  assign sweep_advance = sweeping;

  // The pop strobe is gated by RST so a reset cycle never consumes a spike.
  assign FIFO_r_en_o    = (state_r == ST_FETCH) && !FIFO_empty_i && !RST;
  assign count_o        = count_r;
  assign neuron_idx_o   = sweep_idx;
  assign neuron_event_o = sweeping && (sweep_phase == PHASE_A);
  assign neuron_write_o = sweeping && (sweep_phase == PHASE_B);
  assign neuron_tref_o  = (state_r == ST_FIRE);
  assign busy_o         = (state_r != ST_IDLE);
  assign tick_done_o    = (state_r == ST_DONE);

`ifdef SPIKE_SCHED_PERF_EN
  logic [15:0] pop_cnt_r;
  logic [15:0] evt_count_r;

  // Pops are counted per tick and published when the tick completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pop_cnt_r   <= 16'd0;
      evt_count_r <= 16'd0;
    end else begin
      if ((state_r == ST_IDLE) && start_i) begin
        pop_cnt_r <= 16'd0;
      end else if (FIFO_r_en_o) begin
        pop_cnt_r <= sat_inc16(pop_cnt_r);
      end else begin
        pop_cnt_r <= pop_cnt_r;
      end
      if (state_r == ST_DONE) begin
        evt_count_r <= pop_cnt_r;
      end else begin
        evt_count_r <= evt_count_r;
      end
    end
  end

  assign evt_count_o = evt_count_r;
`endif

endmodule

// File: doc/spike_event_scheduler.md
SPIKE_EVENT_SCHEDULER -- requirements
Module: spike_event_scheduler

Interface
REQ-001 SHALL have parameter N, default 256, number of neurons.
REQ-002 SHALL have parameter M, default 8, neuron/address width, equal to log2(N).
REQ-003 SHALL have parameter INPUT_RESO, default 8, tick width.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  one-cycle pulse that begins processing of one tick.
REQ-007 SHALL have port max_neuron_i  input  M  index of the last neuron to sweep.
REQ-008 SHALL have port spikecore_done_i  input  1  level; spike core has finished filling the FIFO for this tick.
REQ-009 SHALL have port FIFO_empty_i  input  1  input-spike FIFO is empty.
REQ-010 SHALL have port FIFO_r_data_i  input  M  presynaptic address; valid one cycle after FIFO_r_en_o.
REQ-011 SHALL have port FIFO_r_en_o  output  1  FIFO pop strobe.
REQ-012 SHALL have port count_o  output  M  latched presynaptic address of the current event.
REQ-013 SHALL have port neuron_idx_o  output  M  neuron currently addressed.
REQ-014 SHALL have port neuron_event_o  output  1  read/integrate strobe to the neuron and synaptic cores.
REQ-015 SHALL have port neuron_write_o  output  1  state write-back strobe.
REQ-016 SHALL have port neuron_tref_o  output  1  end-of-tick fire/refractory pass qualifier.
REQ-017 SHALL have port busy_o  output  1  high whenever the state is not IDLE.
REQ-018 SHALL have port tick_done_o  output  1  one-cycle pulse when a tick completes.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, LATCH, INTEG, FIRE, DONE.
REQ-020 SHALL leave IDLE for FETCH on start_i and sample max_neuron_i into an internal register in that cycle.
REQ-021 SHALL ignore start_i in every state other than IDLE.
REQ-022 In FETCH, when FIFO_empty_i=0, SHALL assert FIFO_r_en_o for exactly one cycle and go to LATCH.
REQ-023 In FETCH, when FIFO_empty_i=1 and spikecore_done_i=0, SHALL stay in FETCH with no pop.
REQ-024 In FETCH, when FIFO_empty_i=1 and spikecore_done_i=1, SHALL go to FIRE with neuron_idx_o=0.
REQ-025 LATCH SHALL register FIFO_r_data_i into count_o, set neuron_idx_o=0 and go to INTEG.
REQ-026 INTEG and FIRE SHALL spend two cycles per neuron: phase A with neuron_event_o=1, then phase B with neuron_write_o=1; strobes never overlap.
REQ-027 In FIRE, neuron_tref_o SHALL be 1 in both phases; it is 0 in every other state.
REQ-028 After phase B, SHALL increment neuron_idx_o unless it equals the sampled max; at the max, INTEG returns to FETCH and FIRE goes to DONE.
REQ-029 The terminal compare SHALL be an equality test on M bits, so max=N-1 ends without wrap and max=0 sweeps exactly one neuron.
REQ-030 DONE SHALL assert tick_done_o for one cycle and return to IDLE.
REQ-031 Latency from start_i to tick_done_o with an empty FIFO and done=1 SHALL be 2*(max+1)+2 cycles.
REQ-032 Each consumed spike SHALL add 2 + 2*(max+1) cycles.

Reset
REQ-033 RST SHALL force IDLE in any state, including mid-sweep, and clear count_o, neuron_idx_o, the sampled max and all strobes to 0; no FIFO pop occurs in the reset cycle.
REQ-034 After reset, busy_o=0 and tick_done_o=0.

Configuration
REQ-035 With SPIKE_SCHED_PERF_EN defined, SHALL add output evt_count_o [15:0] giving the number of FIFO pops in the last completed tick, updated at DONE, saturating at 16'hFFFF and cleared by RST.
REQ-036 Without SPIKE_SCHED_PERF_EN, SHALL omit the port and its counter.

Structure
REQ-037 The state enum and phase encoding SHALL live in the shared tinyodin_pkg.
REQ-038 The neuron-index counter and phase toggle SHALL be one sub-module, neuron_sweep_counter, instantiated once and reused by INTEG and FIRE.

Verification
REQ-039 Verify: max=3, FIFO empty, done=1, start pulse -> 4 FIRE neurons, tref=1 throughout, tick_done_o 10 cycles after start.
REQ-040 Verify: FIFO holds {5, 9}, max=1 -> count_o=5 then 9, each with idx 0,1 event/write pairs, then FIRE, done after 18 cycles.
REQ-041 Verify: FIFO empty and done=0 for 20 cycles, then push 7 -> FETCH holds with no pops, then pops once and integrates with count_o=7.
REQ-042 Verify: max=255 -> idx reaches 255 and the sweep ends without returning to 0.
REQ-043 Verify: RST asserted in INTEG at idx=2 -> next cycle IDLE, all outputs 0, no extra pop.
REQ-044 Verify: SPIKE_SCHED_PERF_EN with 3 spikes -> evt_count_o=3 after tick_done_o; start_i pulses while busy have no effect.
